alu_console: RTL and testbench
==============================

ALU_CONSOLE -- requirements
Module: alu_console

Interface
REQ-001 SHALL have parameter NB_DATA, default 8, operand width (signed two's complement).
REQ-002 SHALL have parameter NB_OP, default 6, opcode width.
REQ-003 SHALL have parameter NB_OUT, default 16, result width, NB_OUT >= NB_DATA+1.
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, stable-high cycles to accept a button press (>= 1).
REQ-005 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-006 SHALL have port i_reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port switches  input  NB_DATA  raw data/opcode source (low NB_OP bits for opcode).
REQ-008 SHALL have ports btn_set_operand1, btn_set_operand2, btn_set_operator, btn_accumulate  input  1 each  raw asynchronous buttons.
REQ-009 SHALL have port leds  output  NB_OUT  registered signed result.
REQ-010 SHALL have port o_valid  output  1  leds holds a result of all three currently loaded values.
REQ-011 SHALL have port o_overflow  output  1  registered result not representable in NB_DATA signed.
REQ-012 SHALL have port o_loaded  output  3  load flags {operator, operand2, operand1}.

Function
REQ-013 Each button SHALL pass a 2-flop synchronizer, then a per-button counter counting consecutive synchronized-high cycles, reset to 0 on any low cycle.
REQ-014 A one-cycle pulse SHALL fire exactly when a counter reaches DEBOUNCE_CYCLES; counter saturates, so a held button yields one pulse; next pulse requires release.
REQ-015 Latency: raw button high before edge 0 and held -> target register holds new value after edge DEBOUNCE_CYCLES+2; leds/o_valid/o_overflow update after the following edge.
REQ-016 Pulses in same cycle SHALL resolve by priority operand1 > operand2 > operator > accumulate; lower-priority pulses that cycle are discarded.
REQ-017 operand1 pulse: operand1 <= switches, o_loaded[0] <= 1; operand2 likewise with o_loaded[1]; operator pulse: opcode <= switches[NB_OP-1:0], o_loaded[2] <= 1.
REQ-018 FSM states: WAIT (o_loaded != 3'b111) and READY (all set); WAIT->READY when last flag sets; READY->WAIT only on reset; no other transitions.
REQ-019 In READY every cycle: leds <= f(operand1, operand2, opcode), o_valid <= 1; in WAIT leds holds, o_valid = 0.
REQ-020 Opcodes (NB_OP=6): ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRA 000011, SRL 000010; any other -> result 0.
REQ-021 Arithmetic: operands sign-extended to NB_OUT before ADD/SUB; logic ops on sign-extended values; SRA/SRL shift sign-extended operand1 by operand2[$clog2(NB_DATA):0] unsigned, SRL zero-filling from bit NB_OUT-1.
REQ-022 o_overflow <= 1 when registered result is outside [-2^(NB_DATA-1), 2^(NB_DATA-1)-1], else 0; updated with leds.
REQ-023 accumulate pulse with o_valid=1: operand1 <= leds[NB_DATA-1:0] (truncated), flags unchanged; with o_valid=0: ignored.
REQ-024 Loading a new operand/opcode in READY SHALL keep READY; new result appears next edge.

Reset
REQ-025 On i_reset high at an edge: operands, opcode, leds <= 0; o_valid, o_overflow <= 0; o_loaded <= 3'b000; state <= WAIT; synchronizers and counters <= 0.
REQ-026 Reset SHALL take priority over any pulse that cycle; a button held through reset release SHALL need full DEBOUNCE_CYCLES again after release of reset.

Verification (DEBOUNCE_CYCLES=4, defaults otherwise)
REQ-027 Load op1=5, op2=-3 (0xFD), op=ADD -> leds=0x0002, o_valid=1, o_overflow=0, o_loaded=3'b111.
REQ-028 Button high 3 cycles, low 1, high 3 -> no load; held 10 cycles -> exactly one load at edge 6.
REQ-029 op1=100, op2=100, ADD -> leds=200 (0x00C8), o_overflow=1; accumulate -> operand1=0xC8 (-56), next leds=44 (0x002C), o_overflow=0.
REQ-030 op1=0x80, op2=2, SRA -> leds=0xFFE0; opcode SRL -> 0x3FE0; opcode 111111 -> 0x0000.
REQ-031 operand1 and operand2 pulses same cycle -> only operand1 loaded, o_loaded=3'b001.
REQ-032 Reset asserted while READY with leds=0x0002 -> next edge all outputs 0, o_loaded=0; accumulate before reload ignored.

Source files
------------

// File: rtl/alu_console.sv
// alu_console: debounced-button console that loads two signed operands and an
//   opcode from switches, then continuously drives the ALU result on leds.
// Latency: a held button loads its register DEBOUNCE_CYCLES+2 edges after the
//   raw press; leds/o_valid/o_overflow follow one edge later.
// Backpressure: none; a button is a one-shot event. Same-cycle pulses resolve
//   by fixed priority and the losers are dropped.
//
// Ports:
//   clk              system clock, rising edge
//   i_reset          synchronous active-high reset
//   switches         operand / opcode source (opcode = low NB_OP bits)
//   btn_set_operand1 / btn_set_operand2 / btn_set_operator / btn_accumulate
//                    raw asynchronous push buttons
//   leds             registered signed result, NB_OUT bits
//   o_valid          leds reflects the currently loaded operands and opcode
//   o_overflow       leds value does not fit in NB_DATA signed bits
//   o_loaded         {operator, operand2, operand1} load flags
module alu_console #(
  parameter int NB_DATA         = 8,
  parameter int NB_OP           = 6,
  parameter int NB_OUT          = 16,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic [NB_DATA-1:0] switches,
  input  logic              btn_set_operand1,
  input  logic              btn_set_operand2,
  input  logic              btn_set_operator,
  input  logic              btn_accumulate,
  output logic [NB_OUT-1:0] leds,
  output logic              o_valid,
  output logic              o_overflow,
  output logic [2:0]        o_loaded
);

  // Counter must be able to hold DEBOUNCE_CYCLES itself (saturation value).
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  // Shift amount takes one bit more than log2(NB_DATA), so shifts of up to
  // 2*NB_DATA-1 positions are possible on the widened operand.
  localparam int SW = $clog2(NB_DATA) + 1;

  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
  localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
  localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
  localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
  localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
  localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
  localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);
  localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);

  localparam logic [0:0] ST_WAIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  // Button index: 0 operand1, 1 operand2, 2 operator, 3 accumulate.
  // Index order doubles as priority order (lowest index wins).
  localparam int BTN_OP1 = 0;
  localparam int BTN_OP2 = 1;
  localparam int BTN_OPC = 2;
  localparam int BTN_ACC = 3;

  logic [3:0]    btn_raw;
  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    pulse;
  logic [CW-1:0] cnt [4];

  logic [NB_DATA-1:0] operand1;
  logic [NB_DATA-1:0] operand2;
  logic [NB_OP-1:0]   opcode;
  logic [0:0]         state;

  logic [NB_OUT-1:0]  ext1;
  logic [NB_OUT-1:0]  ext2;
  logic [SW-1:0]      shamt;
  logic [NB_OUT-1:0]  result;
  logic [NB_OUT-NB_DATA:0] result_top;
  logic               result_ovf;
  logic [2:0]         loaded_next;

  assign btn_raw = {btn_accumulate, btn_set_operator, btn_set_operand2, btn_set_operand1};

  // ---------------------------------------------------------------------------
  // Synchronizers and debounce counters.
  // The pulse is registered: it is raised on the edge where the counter steps
  // from DEBOUNCE_CYCLES-1 to DEBOUNCE_CYCLES, so it is high exactly while the
  // counter first sits at its saturation value. Holding the button keeps the
  // counter saturated and never re-fires; any low cycle clears it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (i_reset) begin
      sync1 <= '0;
      sync2 <= '0;
      pulse <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      for (int i = 0; i < 4; i++) begin
        pulse[i] <= sync2[i] && (cnt[i] == CNT_MAX - 1'b1);
        if (!sync2[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] != CNT_MAX) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // ALU datapath on sign-extended operands.
  // ---------------------------------------------------------------------------
  assign ext1  = {{(NB_OUT-NB_DATA){operand1[NB_DATA-1]}}, operand1};
  assign ext2  = {{(NB_OUT-NB_DATA){operand2[NB_DATA-1]}}, operand2};
  assign shamt = operand2[SW-1:0];

  always_comb begin
    result = '0;
    case (opcode)
      OP_ADD:  result = ext1 + ext2;
      OP_SUB:  result = ext1 - ext2;
      OP_AND:  result = ext1 & ext2;
      OP_OR:   result = ext1 | ext2;
      OP_XOR:  result = ext1 ^ ext2;
      OP_NOR:  result = ~(ext1 | ext2);
      OP_SRA:  result = $signed(ext1) >>> shamt;
      // Logical shift zero-fills from the top of the widened value, so the
      // sign-extension bits of a negative operand1 shift down into the result.
      OP_SRL:  result = ext1 >> shamt;
      default: result = '0;
    endcase
  end

  // The result fits NB_DATA signed bits iff every bit from NB_DATA-1 upward
  // is a copy of the sign bit.
  assign result_top = result[NB_OUT-1:NB_DATA-1];
  assign result_ovf = ~((&result_top) | ~(|result_top));

  // ---------------------------------------------------------------------------
  // Load flags after this cycle's (single, priority-selected) pulse.
  // ---------------------------------------------------------------------------
  always_comb begin
    loaded_next = o_loaded;
    if (pulse[BTN_OP1]) begin
      loaded_next[0] = 1'b1;
    end else if (pulse[BTN_OP2]) begin
      loaded_next[1] = 1'b1;
    end else if (pulse[BTN_OPC]) begin
      loaded_next[2] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Operand / opcode registers, control FSM and registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (i_reset) begin
      operand1   <= '0;
      operand2   <= '0;
      opcode     <= '0;
      o_loaded   <= 3'b000;
      state      <= ST_WAIT;
      leds       <= '0;
      o_valid    <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      if (pulse[BTN_OP1]) begin
        operand1 <= switches;
      end else if (pulse[BTN_OP2]) begin
        operand2 <= switches;
      end else if (pulse[BTN_OPC]) begin
        opcode <= switches[NB_OP-1:0];
      end else if (pulse[BTN_ACC] && o_valid) begin
        // Feed the displayed result back as operand1, truncated to operand width.
        operand1 <= leds[NB_DATA-1:0];
      end

      o_loaded <= loaded_next;

      case (state)
        ST_WAIT: begin
          if (loaded_next == 3'b111) begin
            state <= ST_READY;
          end
        end
        default: begin
          // READY is left only through reset.
          state <= ST_READY;
        end
      endcase

      if (state == ST_READY) begin
        leds       <= result;
        o_overflow <= result_ovf;
        o_valid    <= 1'b1;
      end else begin
        o_valid    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_console.sv
module tb_alu_console;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [7:0]  switches;
  logic [3:0]  btn;
  logic [15:0] leds;
  logic        o_valid;
  logic        o_overflow;
  logic [2:0]  o_loaded;

  int total = 0;
  int bad   = 0;

  // Reference state: what the console should currently hold.
  logic [7:0] m_op1;
  logic [7:0] m_op2;
  logic [5:0] m_opc;

  always #5 clk = ~clk;

  alu_console #(
    .NB_DATA(8), .NB_OP(6), .NB_OUT(16), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .i_reset(i_reset),
    .switches(switches),
    .btn_set_operand1(btn[0]),
    .btn_set_operand2(btn[1]),
    .btn_set_operator(btn[2]),
    .btn_accumulate(btn[3]),
    .leds(leds),
    .o_valid(o_valid),
    .o_overflow(o_overflow),
    .o_loaded(o_loaded)
  );

  // Behavioural reference: plain integer arithmetic, truncated to 16 bits.
  function automatic logic [15:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                          input logic [5:0] op);
    int sa;
    int sb;
    int sh;
    int r;
    sa = $signed(a);
    sb = $signed(b);
    sh = int'(b[3:0]);
    case (op)
      6'b100000: r = sa + sb;
      6'b100010: r = sa - sb;
      6'b100100: r = sa & sb;
      6'b100101: r = sa | sb;
      6'b100110: r = sa ^ sb;
      6'b100111: r = ~(sa | sb);
      6'b000011: r = sa >>> sh;
      6'b000010: r = (sa & 32'h0000FFFF) >> sh;
      default:   r = 0;
    endcase
    return r[15:0];
  endfunction

  function automatic logic ref_ovf(input logic [15:0] v);
    int s;
    s = $signed(v);
    return (s < -128) || (s > 127);
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    i_reset = 1'b1;
    btn = 4'b0000;
    repeat (2) @(posedge clk);
    #1 i_reset = 1'b0;
    @(negedge clk);
  endtask

  // Hold the buttons in mask for 8 edges with switches at val, release, settle.
  task automatic press(input logic [3:0] mask, input logic [7:0] val);
    @(posedge clk); #1;
    switches = val;
    btn = mask;
    repeat (8) @(posedge clk);
    #1 btn = 4'b0000;
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (leds !== 16'h0000) begin $display("FAIL reset_leds got=%h exp=%h", leds, 16'h0000); bad++; end
    total++; if (o_valid !== 1'b0) begin $display("FAIL reset_valid got=%b exp=0", o_valid); bad++; end
    total++; if (o_overflow !== 1'b0) begin $display("FAIL reset_ovf got=%b exp=0", o_overflow); bad++; end
    total++; if (o_loaded !== 3'b000) begin $display("FAIL reset_loaded got=%b exp=000", o_loaded); bad++; end
  endtask

  task automatic test_add();
    do_reset();
    press(4'b0001, 8'd5);
    press(4'b0010, 8'hFD);
    press(4'b0100, 8'b00100000);
    total++; if (leds !== 16'h0002) begin $display("FAIL add_leds got=%h exp=0002", leds); bad++; end
    total++; if (o_valid !== 1'b1) begin $display("FAIL add_valid got=%b exp=1", o_valid); bad++; end
    total++; if (o_overflow !== 1'b0) begin $display("FAIL add_ovf got=%b exp=0", o_overflow); bad++; end
    total++; if (o_loaded !== 3'b111) begin $display("FAIL add_loaded got=%b exp=111", o_loaded); bad++; end
  endtask

  task automatic test_debounce();
    do_reset();
    // Two bursts of 3 high cycles around a 1-cycle gap must not register.
    @(posedge clk); #1;
    switches = 8'h55;
    btn = 4'b0001;
    repeat (3) @(posedge clk);
    #1 btn = 4'b0000;
    @(posedge clk);
    #1 btn = 4'b0001;
    repeat (3) @(posedge clk);
    #1 btn = 4'b0000;
    repeat (5) @(posedge clk);
    @(negedge clk);
    total++; if (o_loaded !== 3'b000) begin $display("FAIL bounce_noload got=%b exp=000", o_loaded); bad++; end
    // Held 10 edges: load lands exactly at edge 6, and only once.
    @(posedge clk); #1;
    switches = 8'h11;
    btn = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      if (k == 7) begin
        #1 switches = 8'h33;
      end
      @(negedge clk);
      if (k == 5) begin
        total++; if (o_loaded[0] !== 1'b0) begin $display("FAIL hold_edge5 got=%b exp=0", o_loaded[0]); bad++; end
      end
      if (k == 6) begin
        total++; if (o_loaded[0] !== 1'b1) begin $display("FAIL hold_edge6 got=%b exp=1", o_loaded[0]); bad++; end
      end
    end
    #1 btn = 4'b0000;
    repeat (4) @(posedge clk);
    press(4'b0010, 8'h01);
    press(4'b0100, 8'b00100000);
    total++; if (leds !== ref_alu(8'h11, 8'h01, 6'b100000)) begin
      $display("FAIL hold_single_load got=%h exp=%h", leds, ref_alu(8'h11, 8'h01, 6'b100000)); bad++; end
  endtask

  task automatic test_overflow_acc();
    do_reset();
    press(4'b0001, 8'd100);
    press(4'b0010, 8'd100);
    press(4'b0100, 8'b00100000);
    total++; if (leds !== 16'h00C8) begin $display("FAIL ovf_leds got=%h exp=00c8", leds); bad++; end
    total++; if (o_overflow !== 1'b1) begin $display("FAIL ovf_flag got=%b exp=1", o_overflow); bad++; end
    press(4'b1000, 8'h00);
    total++; if (leds !== 16'h002C) begin $display("FAIL acc_leds got=%h exp=002c", leds); bad++; end
    total++; if (o_overflow !== 1'b0) begin $display("FAIL acc_ovf got=%b exp=0", o_overflow); bad++; end
  endtask

  task automatic test_shifts();
    do_reset();
    press(4'b0001, 8'h80);
    press(4'b0010, 8'd2);
    press(4'b0100, 8'b00000011);
    total++; if (leds !== 16'hFFE0) begin $display("FAIL sra got=%h exp=ffe0", leds); bad++; end
    press(4'b0100, 8'b00000010);
    total++; if (leds !== 16'h3FE0) begin $display("FAIL srl got=%h exp=3fe0", leds); bad++; end
    press(4'b0100, 8'b00111111);
    total++; if (leds !== 16'h0000) begin $display("FAIL badop got=%h exp=0000", leds); bad++; end
  endtask

  task automatic test_priority();
    do_reset();
    press(4'b0011, 8'h07);
    total++; if (o_loaded !== 3'b001) begin $display("FAIL prio_loaded got=%b exp=001", o_loaded); bad++; end
    // operand2 was dropped: load it now and check operand1 carries 0x07 only.
    press(4'b0010, 8'h02);
    press(4'b0100, 8'b00100010);
    total++; if (leds !== ref_alu(8'h07, 8'h02, 6'b100010)) begin
      $display("FAIL prio_result got=%h exp=%h", leds, ref_alu(8'h07, 8'h02, 6'b100010)); bad++; end
  endtask

  task automatic test_reset_ready();
    do_reset();
    press(4'b0001, 8'd5);
    press(4'b0010, 8'hFD);
    press(4'b0100, 8'b00100000);
    total++; if (leds !== 16'h0002) begin $display("FAIL rr_pre got=%h exp=0002", leds); bad++; end
    @(posedge clk); #1 i_reset = 1'b1;
    @(posedge clk); #1 i_reset = 1'b0;
    @(negedge clk);
    total++; if (leds !== 16'h0000) begin $display("FAIL rr_leds got=%h exp=0000", leds); bad++; end
    total++; if (o_valid !== 1'b0) begin $display("FAIL rr_valid got=%b exp=0", o_valid); bad++; end
    total++; if (o_loaded !== 3'b000) begin $display("FAIL rr_loaded got=%b exp=000", o_loaded); bad++; end
    press(4'b1000, 8'hAA);
    total++; if (o_loaded !== 3'b000) begin $display("FAIL rr_acc_loaded got=%b exp=000", o_loaded); bad++; end
    total++; if (o_valid !== 1'b0) begin $display("FAIL rr_acc_valid got=%b exp=0", o_valid); bad++; end
  endtask

  task automatic test_random();
    logic [5:0]  ops [8];
    logic [15:0] exp;
    logic [7:0]  v;
    int          b;
    ops = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
            6'b100110, 6'b100111, 6'b000011, 6'b000010};
    do_reset();
    m_op1 = 8'($urandom);
    m_op2 = 8'($urandom);
    m_opc = ops[$urandom_range(0, 7)];
    press(4'b0001, m_op1);
    press(4'b0010, m_op2);
    press(4'b0100, {2'b00, m_opc});
    for (int i = 0; i < 12; i++) begin
      b = $urandom_range(0, 3);
      v = 8'($urandom);
      if (b == 2 && $urandom_range(0, 3) != 0) v = {2'b00, ops[$urandom_range(0, 7)]};
      case (b)
        0: m_op1 = v;
        1: m_op2 = v;
        2: m_opc = v[5:0];
        default: begin
          exp = ref_alu(m_op1, m_op2, m_opc);
          m_op1 = exp[7:0];
        end
      endcase
      press(4'(1 << b), v);
      exp = ref_alu(m_op1, m_op2, m_opc);
      total++; if (leds !== exp) begin
        $display("FAIL rand_leds[%0d] got=%h exp=%h", i, leds, exp); bad++; end
      total++; if (o_overflow !== ref_ovf(exp)) begin
        $display("FAIL rand_ovf[%0d] got=%b exp=%b", i, o_overflow, ref_ovf(exp)); bad++; end
    end
  endtask

  initial begin
    i_reset  = 1'b1;
    switches = 8'h00;
    btn      = 4'b0000;
    repeat (2) @(posedge clk);
    test_reset();
    test_add();
    test_debounce();
    test_overflow_acc();
    test_shifts();
    test_priority();
    test_reset_ready();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
